// File: rtl/viterbi_ber_scoreboard_if.sv
// Stream/result bundle between the Viterbi test chain and the BER scoreboard.
// master: the side driving reference/decoded bits and start controls.
// slave : the scoreboard itself.
interface viterbi_ber_scoreboard_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned SKIP_W = 16
);
  logic              start_i;
  logic              auto_sync_i;
  logic [SKIP_W-1:0] skip_i;
  logic              ref_valid_i;
  logic              ref_bit_i;
  logic              dut_valid_i;
  logic              dut_bit_i;
  logic [CNT_W-1:0]  good_o;
  logic [CNT_W-1:0]  bad_o;
  logic [CNT_W-1:0]  slip_o;
  logic              locked_o;
  logic              fail_o;
  logic              overflow_o;
  logic              bit_err_o;

  modport master (
    output start_i, auto_sync_i, skip_i, ref_valid_i, ref_bit_i, dut_valid_i, dut_bit_i,
    input  good_o, bad_o, slip_o, locked_o, fail_o, overflow_o, bit_err_o
  );

  modport slave (
    input  start_i, auto_sync_i, skip_i, ref_valid_i, ref_bit_i, dut_valid_i, dut_bit_i,
    output good_o, bad_o, slip_o, locked_o, fail_o, overflow_o, bit_err_o
  );
endinterface

// File: rtl/viterbi_ber_scoreboard.sv
// BER scoreboard: buffers reference bits in a FIFO, aligns them to the decoded
// stream (fixed skip, optional slip search), then counts good/bad bits.
module viterbi_ber_scoreboard #(
  parameter int unsigned DEPTH        = 2048,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned SKIP_W       = 16,
  parameter int unsigned SYNC_WIN     = 64,
  parameter int unsigned SYNC_MAX_ERR = 2
) (
  input logic                     clk,
  input logic                     rst,
  viterbi_ber_scoreboard_if.slave bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned WIN_W = $clog2(SYNC_WIN + 1);
  localparam int unsigned ERR_W = $clog2(SYNC_MAX_ERR + 2);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SYNC_WIN);
  localparam logic [ERR_W-1:0] ERR_LIM  = ERR_W'(SYNC_MAX_ERR);
  localparam logic [CNT_W-1:0] SLIP_LIM = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SKIP, S_SYNC, S_SLIP, S_TRACK, S_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  good_q, good_d;
  logic [CNT_W-1:0]  bad_q, bad_d;
  logic [CNT_W-1:0]  slip_q, slip_d;
  logic              ovf_q, ovf_d;
  logic              bit_err_q, bit_err_d;
  logic              mem_q [DEPTH];

  logic empty, full, ref_head;
  logic push, push_ok, pop, cmp, mism;

  // FIFO status from pointers; the extra wrap bit separates full from empty
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    ref_head = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Run control, FIFO bookkeeping, alignment search and error counting
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    skip_cnt_d = skip_cnt_q;
    win_d      = win_q;
    err_d      = err_q;
    good_d     = good_q;
    bad_d      = bad_q;
    slip_d     = slip_q;
    ovf_d      = ovf_q;
    bit_err_d  = 1'b0;
    push       = 1'b0;
    push_ok    = 1'b0;
    pop        = 1'b0;
    cmp        = 1'b0;
    mism       = 1'b0;

    if (bus.start_i) begin
      // a start from any state begins a fresh run with an empty FIFO
      state_d    = S_SKIP;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      skip_cnt_d = bus.skip_i;
      win_d      = '0;
      err_d      = '0;
      good_d     = '0;
      bad_d      = '0;
      slip_d     = '0;
      ovf_d      = 1'b0;
    end else begin
      cmp  = bus.dut_valid_i && !empty && (state_q == S_SYNC || state_q == S_TRACK);
      mism = cmp && (bus.dut_bit_i != ref_head);
      // the slip pop lives in its own state, so it can never coincide with a compare pop
      pop  = cmp || (state_q == S_SLIP && !empty);
      push = bus.ref_valid_i && (state_q != S_IDLE);

      if (push) begin
        if (!full || pop) begin
          push_ok  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
        S_SKIP: begin
          if (bus.dut_valid_i && skip_cnt_q != '0) begin
            skip_cnt_d = skip_cnt_q - 1'b1;
          end
          if (skip_cnt_d == '0) begin
            state_d = S_SYNC;
          end
        end
        S_SYNC: begin
          if (cmp) begin
            win_d = win_q + 1'b1;
            if (mism && err_q != '1) begin
              err_d = err_q + 1'b1;
            end
            if (win_d == WIN_LAST) begin
              if (err_d <= ERR_LIM) begin
                state_d = S_TRACK;
              end else if (bus.auto_sync_i) begin
                state_d = S_SLIP;
              end else begin
                state_d = S_FAIL;
              end
              win_d = '0;
              err_d = '0;
            end
          end
        end
        S_SLIP: begin
          // waits here until a reference bit exists to drop
          if (!empty) begin
            if (slip_q != '1) begin
              slip_d = slip_q + 1'b1;
            end
            state_d = (slip_d >= SLIP_LIM) ? S_FAIL : S_SYNC;
          end
        end
        S_TRACK: begin
          if (cmp) begin
            if (mism) begin
              bit_err_d = 1'b1;
              if (bad_q != '1) begin
                bad_d = bad_q + 1'b1;
              end
            end else if (good_q != '1) begin
              good_d = good_q + 1'b1;
            end
          end
        end
        S_FAIL: begin
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      skip_cnt_q <= '0;
      win_q      <= '0;
      err_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      slip_q     <= '0;
      ovf_q      <= 1'b0;
      bit_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      skip_cnt_q <= skip_cnt_d;
      win_q      <= win_d;
      err_q      <= err_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      slip_q     <= slip_d;
      ovf_q      <= ovf_d;
      bit_err_q  <= bit_err_d;
    end
  end

  // Reference bit storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.ref_bit_i;
    end
  end

  assign bus.good_o     = good_q;
  assign bus.bad_o      = bad_q;
  assign bus.slip_o     = slip_q;
  assign bus.locked_o   = (state_q == S_TRACK);
  assign bus.fail_o     = (state_q == S_FAIL);
  assign bus.overflow_o = ovf_q;
  assign bus.bit_err_o  = bit_err_q;
endmodule
